// File: rtl/mem_access_unit_if.sv
// Bundle of core-side request signals and memory-side port signals for mem_access_unit.
// slave = the access unit itself; master = the core plus data memory driving it.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy;
    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_d_out;
    logic [31:0]       mem_d_in;
    logic              mem_rd;
    logic              mem_wr;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_d_in,
        output rdata, busy, done, misaligned, mem_adr, mem_d_out, mem_rd, mem_wr
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_d_in,
        input  rdata, busy, done, misaligned, mem_adr, mem_d_out, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit over a word-wide memory port; sub-word stores use read-modify-write.
// Optional alignment checking is enabled by defining MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sx;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_rdata;
    logic              r_mis;
    logic [31:0]       r_d_out;
    logic              w_mis;

`ifdef MAU_ALIGN_CHECK_EN
    assign w_mis = ((bus.size == 2'b01) && bus.addr[0]) ||
                   (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    // Pull the addressed lane(s) out of a memory word and extend to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{sx & b[7]}}, b};
            2'b01:   return {{16{sx & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] m;
        m = w;
        case (sz)
            2'b00: m[{lane, 3'b000} +: 8] = d[7:0];
            2'b01: begin
                if (lane[1]) m[31:16] = d[15:0];
                else         m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sx    <= 1'b0;
            r_lane  <= 2'b00;
            r_wdata <= '0;
            r_adr   <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
            r_d_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_size  <= bus.size;
                        r_sx    <= bus.sign_ext;
                        r_lane  <= bus.addr[1:0];
                        r_wdata <= bus.wdata;
                        r_adr   <= {bus.addr[ADDR_W-1:2], 2'b00};
                        r_mis   <= w_mis;
                        r_rdata <= '0;
                        if (w_mis) begin
                            r_state <= S_DONE;
                        end else if (bus.we && bus.size[1]) begin
                            r_d_out <= bus.wdata;
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                // Read data is captured here either as the load result or as the RMW base word.
                S_RD: begin
                    if (r_we) begin
                        r_d_out <= merge(bus.mem_d_in, r_wdata, r_size, r_lane);
                        r_state <= S_WR;
                    end else begin
                        r_rdata <= extract(bus.mem_d_in, r_size, r_lane, r_sx);
                        r_state <= S_DONE;
                    end
                end
                S_WR:    r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata      = r_rdata;
    assign bus.misaligned = r_mis;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.mem_rd     = (r_state == S_RD);
    assign bus.mem_wr     = (r_state == S_WR);
    assign bus.mem_adr    = r_adr;
    assign bus.mem_d_out  = r_d_out;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-array data memory.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_rd = 0, n_wr = 0, n_both = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_adr = '0;
    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32)) bif ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    assign bif.mem_d_in = mem[bif.mem_adr[7:2]];

    always @(posedge clk) begin
        if (bif.mem_wr) mem[bif.mem_adr[7:2]] <= bif.mem_d_out;
    end

    always @(posedge clk) begin
        if (bif.mem_rd) begin n_rd++; last_adr = bif.mem_adr; end
        if (bif.mem_wr) begin n_wr++; last_wdata = bif.mem_d_out; last_adr = bif.mem_adr; end
        if (bif.mem_rd && bif.mem_wr) n_both++;
    end

    // Issue one request, hold req until done, return the cycles from the sampling edge to done.
    task automatic run_req(input logic we_i, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, output int lat);
        @(negedge clk);
        bif.req = 1'b1; bif.we = we_i; bif.size = sz; bif.sign_ext = sx;
        bif.addr = a; bif.wdata = wd;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bif.done) begin lat = i; break; end
        end
        bif.req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bif.busy); end
        checks++; if (bif.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bif.done); end
        checks++; if (bif.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", bif.rdata); end
        checks++; if (bif.misaligned !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b exp=0", bif.misaligned); end
        checks++; if ({bif.mem_rd, bif.mem_wr} !== 2'b00) begin failures++; $display("FAIL rst_rdwr got=%b exp=00", {bif.mem_rd, bif.mem_wr}); end
        checks++; if (bif.mem_adr !== 32'h0 || bif.mem_d_out !== 32'h0) begin failures++; $display("FAIL rst_bus adr=%h dout=%h exp=0/0", bif.mem_adr, bif.mem_d_out); end
        rst = 1'b0;
    endtask

    task automatic test_load_byte();
        int lat; int rd0; int wr0;
        rd0 = n_rd; wr0 = n_wr;
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ldb_lat got=%0d exp=2", lat); end
        checks++; if (bif.rdata !== 32'hFFFFFF88) begin failures++; $display("FAIL ldb_sx got=%h exp=ffffff88", bif.rdata); end
        checks++; if (n_rd - rd0 !== 1 || n_wr - wr0 !== 0 || last_adr !== 32'h10) begin failures++; $display("FAIL ldb_bus rd=%0d wr=%0d adr=%h exp=1/0/10", n_rd - rd0, n_wr - wr0, last_adr); end
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat);
        checks++; if (bif.rdata !== 32'h00000088) begin failures++; $display("FAIL ldb_zx got=%h exp=00000088", bif.rdata); end
    endtask

    task automatic test_load_half();
        int lat;
        run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat);
        checks++; if (lat !== 2 || bif.rdata !== 32'hFFFFAABB) begin failures++; $display("FAIL ldh_lo lat=%0d got=%h exp=2/ffffaabb", lat, bif.rdata); end
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat);
        checks++; if (bif.rdata !== 32'h00008899) begin failures++; $display("FAIL ldh_hi got=%h exp=00008899", bif.rdata); end
    endtask

    task automatic test_store_byte();
        int lat; int rd0; int wr0;
        rd0 = n_rd; wr0 = n_wr;
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL stb_lat got=%0d exp=3", lat); end
        checks++; if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1) begin failures++; $display("FAIL stb_cycles rd=%0d wr=%0d exp=1/1", n_rd - rd0, n_wr - wr0); end
        checks++; if (last_wdata !== 32'h88995ABB) begin failures++; $display("FAIL stb_dout got=%h exp=88995abb", last_wdata); end
        checks++; if (bif.rdata !== 32'h0) begin failures++; $display("FAIL stb_rdata got=%h exp=0", bif.rdata); end
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
        checks++; if (lat !== 2 || bif.rdata !== 32'h88995ABB) begin failures++; $display("FAIL stb_readback lat=%0d got=%h exp=2/88995abb", lat, bif.rdata); end
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat);
        checks++; if (bif.rdata !== 32'h88995ABB) begin failures++; $display("FAIL ld_rsvd got=%h exp=88995abb", bif.rdata); end
    endtask

    task automatic test_store_word();
        int lat; int rd0; int wr0;
        rd0 = n_rd; wr0 = n_wr;
        run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL stw_lat got=%0d exp=2", lat); end
        repeat (3) @(negedge clk);
        checks++; if (n_rd - rd0 !== 0 || n_wr - wr0 !== 1) begin failures++; $display("FAIL stw_cycles rd=%0d wr=%0d exp=0/1", n_rd - rd0, n_wr - wr0); end
        checks++; if (mem[8] !== 32'hDEADBEEF || last_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL stw_mem got=%h dout=%h exp=deadbeef", mem[8], last_wdata); end
        checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL stw_idle busy=%b exp=0", bif.busy); end
    endtask

    task automatic test_store_half_misalign();
        int lat; int rd0; int wr0;
        rd0 = n_rd; wr0 = n_wr;
        run_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, lat);
`ifdef MAU_ALIGN_CHECK_EN
        checks++; if (lat !== 1 || bif.misaligned !== 1'b1) begin failures++; $display("FAIL sth_mis lat=%0d mis=%b exp=1/1", lat, bif.misaligned); end
        checks++; if (n_rd - rd0 !== 0 || n_wr - wr0 !== 0 || bif.rdata !== 32'h0) begin failures++; $display("FAIL sth_noacc rd=%0d wr=%0d rdata=%h exp=0/0/0", n_rd - rd0, n_wr - wr0, bif.rdata); end
        checks++; if (mem[8] !== 32'hDEADBEEF) begin failures++; $display("FAIL sth_mem got=%h exp=deadbeef", mem[8]); end
`else
        checks++; if (lat !== 3 || bif.misaligned !== 1'b0) begin failures++; $display("FAIL sth_lat lat=%0d mis=%b exp=3/0", lat, bif.misaligned); end
        checks++; if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1) begin failures++; $display("FAIL sth_cycles rd=%0d wr=%0d exp=1/1", n_rd - rd0, n_wr - wr0); end
        checks++; if (mem[8] !== 32'hDEAD1234) begin failures++; $display("FAIL sth_mem got=%h exp=dead1234", mem[8]); end
`endif
    endtask

    task automatic test_reset_mid();
        int wr0;
        wr0 = n_wr;
        @(negedge clk);
        bif.req = 1'b1; bif.we = 1'b1; bif.size = 2'b00; bif.sign_ext = 1'b0;
        bif.addr = 32'h10; bif.wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bif.busy !== 1'b1 || bif.mem_rd !== 1'b1) begin failures++; $display("FAIL rmid_rd busy=%b rd=%b exp=1/1", bif.busy, bif.mem_rd); end
        rst = 1'b1; bif.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin failures++; $display("FAIL rmid_idle busy=%b done=%b exp=0/0", bif.busy, bif.done); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_wr - wr0 !== 0 || mem[4] !== 32'h88995ABB) begin failures++; $display("FAIL rmid_mem wr=%0d mem=%h exp=0/88995abb", n_wr - wr0, mem[4]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h00000000;
        bif.req = 1'b0; bif.we = 1'b0; bif.size = 2'b00; bif.sign_ext = 1'b0;
        bif.addr = '0; bif.wdata = '0;
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_store_word();
        test_store_half_misalign();
        test_reset_mid();
        checks++; if (n_both !== 0) begin failures++; $display("FAIL rd_wr_overlap got=%0d exp=0", n_both); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
